// File: rtl/mm_job_sequencer_if.sv
// Job/DMA/compute handshake bundle for mm_job_sequencer.
// MM_SEQ_PERF_CNT_EN adds the performance counter outputs.
interface mm_job_sequencer_if #(
  parameter int ADDR_W   = 32,
  parameter int LENGTH_W = 8
);
  logic                job_start;
  logic [ADDR_W-1:0]   job_base_a, job_base_b, job_base_c;
  logic [LENGTH_W-1:0] job_len_a, job_len_b, job_len_c;
  logic                job_busy;
  logic                job_done;
  logic                job_error;
  logic [1:0]          job_err_phase;
  logic                dma_start_load_a, dma_start_load_b, dma_start_store_c;
  logic [ADDR_W-1:0]   dma_base_addr_a, dma_base_addr_b, dma_base_addr_c;
  logic [LENGTH_W-1:0] dma_length_a, dma_length_b, dma_length_c;
  logic                dma_done_load_a, dma_done_load_b, dma_done_store_c;
  logic                dma_busy;
  logic                mac_start;
  logic                mac_done;
`ifdef MM_SEQ_PERF_CNT_EN
  logic [31:0]         perf_cycles;
  logic [31:0]         perf_dma_cycles;
`endif

  modport master (
    input  job_start, job_base_a, job_base_b, job_base_c,
    input  job_len_a, job_len_b, job_len_c,
    output job_busy, job_done, job_error, job_err_phase,
    output dma_start_load_a, dma_start_load_b, dma_start_store_c,
    output dma_base_addr_a, dma_base_addr_b, dma_base_addr_c,
    output dma_length_a, dma_length_b, dma_length_c,
    input  dma_done_load_a, dma_done_load_b, dma_done_store_c, dma_busy,
    output mac_start,
    input  mac_done
`ifdef MM_SEQ_PERF_CNT_EN
    , output perf_cycles, perf_dma_cycles
`endif
  );

  modport slave (
    output job_start, job_base_a, job_base_b, job_base_c,
    output job_len_a, job_len_b, job_len_c,
    input  job_busy, job_done, job_error, job_err_phase,
    input  dma_start_load_a, dma_start_load_b, dma_start_store_c,
    input  dma_base_addr_a, dma_base_addr_b, dma_base_addr_c,
    input  dma_length_a, dma_length_b, dma_length_c,
    output dma_done_load_a, dma_done_load_b, dma_done_store_c, dma_busy,
    input  mac_start,
    output mac_done
`ifdef MM_SEQ_PERF_CNT_EN
    , input perf_cycles, perf_dma_cycles
`endif
  );
endinterface

// File: rtl/mm_job_sequencer.sv
// Matrix-multiply job controller: LOAD_A -> LOAD_B -> MAC -> STORE_C with per-phase watchdog.
// Optional MM_SEQ_PERF_CNT_EN adds busy-cycle and DMA-wait-cycle counters.
module mm_job_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int LENGTH_W  = 8,
  parameter int TIMEOUT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  mm_job_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, ISSUE_MAC, WAIT_MAC,
    ISSUE_C, WAIT_C, DONE, ERR
  } state_t;

  // Timeout fires on the cycle whose increment would make the counter all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~(TIMEOUT_W'(1));

  state_t               state;
  logic [TIMEOUT_W-1:0] wd;
  logic                 in_phase;
  logic                 advance;
  logic [1:0]           phase;

  always_comb begin
    in_phase = 1'b1;
    advance  = 1'b0;
    phase    = 2'd0;
    case (state)
      ISSUE_A:   advance = (bus.dma_length_a == '0) || !bus.dma_busy;
      WAIT_A:    advance = bus.dma_done_load_a;
      ISSUE_B:   begin phase = 2'd1; advance = (bus.dma_length_b == '0) || !bus.dma_busy; end
      WAIT_B:    begin phase = 2'd1; advance = bus.dma_done_load_b; end
      ISSUE_MAC: begin phase = 2'd2; advance = 1'b1; end
      WAIT_MAC:  begin phase = 2'd2; advance = bus.mac_done; end
      ISSUE_C:   begin phase = 2'd3; advance = (bus.dma_length_c == '0) || !bus.dma_busy; end
      WAIT_C:    begin phase = 2'd3; advance = bus.dma_done_store_c; end
      default:   in_phase = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      wd                    <= '0;
      bus.job_busy          <= 1'b0;
      bus.job_done          <= 1'b0;
      bus.job_error         <= 1'b0;
      bus.job_err_phase     <= 2'd0;
      bus.dma_start_load_a  <= 1'b0;
      bus.dma_start_load_b  <= 1'b0;
      bus.dma_start_store_c <= 1'b0;
      bus.mac_start         <= 1'b0;
      bus.dma_base_addr_a   <= {ADDR_W{1'b0}};
      bus.dma_base_addr_b   <= {ADDR_W{1'b0}};
      bus.dma_base_addr_c   <= {ADDR_W{1'b0}};
      bus.dma_length_a      <= {LENGTH_W{1'b0}};
      bus.dma_length_b      <= {LENGTH_W{1'b0}};
      bus.dma_length_c      <= {LENGTH_W{1'b0}};
    end else begin
      bus.dma_start_load_a  <= 1'b0;
      bus.dma_start_load_b  <= 1'b0;
      bus.dma_start_store_c <= 1'b0;
      bus.mac_start         <= 1'b0;
      bus.job_done          <= 1'b0;

      // A completing event in the final watchdog cycle takes priority over the timeout.
      if (in_phase) begin
        if (advance) begin
          wd <= '0;
        end else if (wd == WD_LAST) begin
          wd                <= '0;
          state             <= ERR;
          bus.job_error     <= 1'b1;
          bus.job_busy      <= 1'b0;
          bus.job_err_phase <= phase;
        end else if (wd != '1) begin
          wd <= wd + 1'b1;
        end
      end

      case (state)
        IDLE: if (bus.job_start) begin
          bus.dma_base_addr_a <= bus.job_base_a;
          bus.dma_base_addr_b <= bus.job_base_b;
          bus.dma_base_addr_c <= bus.job_base_c;
          bus.dma_length_a    <= bus.job_len_a;
          bus.dma_length_b    <= bus.job_len_b;
          bus.dma_length_c    <= bus.job_len_c;
          bus.job_error       <= 1'b0;
          bus.job_busy        <= 1'b1;
          wd                  <= '0;
          state               <= ISSUE_A;
        end
        ISSUE_A: if (advance) begin
          if (bus.dma_length_a != '0) begin
            bus.dma_start_load_a <= 1'b1;
            state                <= WAIT_A;
          end else begin
            state <= ISSUE_B;
          end
        end
        WAIT_A: if (advance) state <= ISSUE_B;
        ISSUE_B: if (advance) begin
          if (bus.dma_length_b != '0) begin
            bus.dma_start_load_b <= 1'b1;
            state                <= WAIT_B;
          end else begin
            state <= ISSUE_MAC;
          end
        end
        WAIT_B: if (advance) state <= ISSUE_MAC;
        ISSUE_MAC: begin
          bus.mac_start <= 1'b1;
          state         <= WAIT_MAC;
        end
        WAIT_MAC: if (advance) state <= ISSUE_C;
        ISSUE_C: if (advance) begin
          if (bus.dma_length_c != '0) begin
            bus.dma_start_store_c <= 1'b1;
            state                 <= WAIT_C;
          end else begin
            bus.job_done <= 1'b1;
            bus.job_busy <= 1'b0;
            state        <= DONE;
          end
        end
        WAIT_C: if (advance) begin
          bus.job_done <= 1'b1;
          bus.job_busy <= 1'b0;
          state        <= DONE;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MM_SEQ_PERF_CNT_EN
  // Counters restart on an accepted job and hold their final values afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.perf_cycles     <= 32'd0;
      bus.perf_dma_cycles <= 32'd0;
    end else if (state == IDLE && bus.job_start) begin
      bus.perf_cycles     <= 32'd0;
      bus.perf_dma_cycles <= 32'd0;
    end else begin
      if (bus.job_busy && bus.perf_cycles != 32'hFFFF_FFFF)
        bus.perf_cycles <= bus.perf_cycles + 32'd1;
      if ((state == WAIT_A || state == WAIT_B || state == WAIT_C) &&
          bus.perf_dma_cycles != 32'hFFFF_FFFF)
        bus.perf_dma_cycles <= bus.perf_dma_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Directed bench for mm_job_sequencer: main instance with a DMA/MAC responder,
// plus a TIMEOUT_W=4 instance driven by hand for the watchdog cases.
module tb_mm_job_sequencer;

  localparam int DMA_DELAY = 10;
  localparam int MAC_DELAY = 20;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  mm_job_sequencer_if #(.ADDR_W(32), .LENGTH_W(8)) bus_main ();
  mm_job_sequencer_if #(.ADDR_W(32), .LENGTH_W(8)) bus_wd ();

  mm_job_sequencer #(.ADDR_W(32), .LENGTH_W(8), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_main)
  );

  mm_job_sequencer #(.ADDR_W(32), .LENGTH_W(8), .TIMEOUT_W(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .bus(bus_wd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: answers each start pulse with a one-cycle done after a fixed delay.
  int a_cnt = 0, b_cnt = 0, c_cnt = 0, m_cnt = 0;
  always @(negedge clk) begin
    bus_main.dma_done_load_a  = 1'b0;
    bus_main.dma_done_load_b  = 1'b0;
    bus_main.dma_done_store_c = 1'b0;
    bus_main.mac_done         = 1'b0;
    if (!rst_n) begin
      a_cnt = 0; b_cnt = 0; c_cnt = 0; m_cnt = 0;
    end else begin
      if (a_cnt > 0) begin a_cnt--; if (a_cnt == 0) bus_main.dma_done_load_a = 1'b1; end
      if (b_cnt > 0) begin b_cnt--; if (b_cnt == 0) bus_main.dma_done_load_b = 1'b1; end
      if (c_cnt > 0) begin c_cnt--; if (c_cnt == 0) bus_main.dma_done_store_c = 1'b1; end
      if (m_cnt > 0) begin m_cnt--; if (m_cnt == 0) bus_main.mac_done = 1'b1; end
      if (bus_main.dma_start_load_a)  a_cnt = DMA_DELAY;
      if (bus_main.dma_start_load_b)  b_cnt = DMA_DELAY;
      if (bus_main.dma_start_store_c) c_cnt = DMA_DELAY;
      if (bus_main.mac_start)         m_cnt = MAC_DELAY;
    end
  end

  // Pulse monitor: high-cycle counts and last-seen cycle of each pulse.
  int n_a = 0, n_b = 0, n_mac = 0, n_c = 0, n_done = 0, n_busy_fall = 0;
  int t_a = 0, t_b = 0, t_mac = 0, t_c = 0, t_done = 0;
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    if (bus_main.dma_start_load_a)  begin n_a++;    t_a = cyc;    end
    if (bus_main.dma_start_load_b)  begin n_b++;    t_b = cyc;    end
    if (bus_main.mac_start)         begin n_mac++;  t_mac = cyc;  end
    if (bus_main.dma_start_store_c) begin n_c++;    t_c = cyc;    end
    if (bus_main.job_done)          begin n_done++; t_done = cyc; end
    if (busy_q && !bus_main.job_busy) n_busy_fall++;
    busy_q = bus_main.job_busy;
  end

  int s_a, s_b, s_mac, s_c, s_done, s_fall;
  logic seen;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic snapshot();
    s_a = n_a; s_b = n_b; s_mac = n_mac; s_c = n_c; s_done = n_done; s_fall = n_busy_fall;
  endtask

  task automatic start_job(input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc,
                           input logic [7:0] la, input logic [7:0] lb, input logic [7:0] lc);
    bus_main.job_base_a = ba; bus_main.job_base_b = bb; bus_main.job_base_c = bc;
    bus_main.job_len_a  = la; bus_main.job_len_b  = lb; bus_main.job_len_c  = lc;
    bus_main.job_start  = 1'b1;
    @(negedge clk);
    bus_main.job_start  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && !bus_main.job_done; i++) @(negedge clk);
    check_output({tag, "_done_seen"}, 32'(bus_main.job_done), 1);
    check_output({tag, "_busy_at_done"}, 32'(bus_main.job_busy), 0);
    @(negedge clk);
    check_output({tag, "_done_one_cycle"}, 32'(bus_main.job_done), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_main.job_start = 1'b0; bus_main.dma_busy = 1'b0;
    bus_main.job_base_a = '0; bus_main.job_base_b = '0; bus_main.job_base_c = '0;
    bus_main.job_len_a = '0; bus_main.job_len_b = '0; bus_main.job_len_c = '0;
    bus_wd.job_start = 1'b0; bus_wd.dma_busy = 1'b0; bus_wd.mac_done = 1'b0;
    bus_wd.dma_done_load_a = 1'b0; bus_wd.dma_done_load_b = 1'b0; bus_wd.dma_done_store_c = 1'b0;
    bus_wd.job_base_a = '0; bus_wd.job_base_b = '0; bus_wd.job_base_c = '0;
    bus_wd.job_len_a = '0; bus_wd.job_len_b = '0; bus_wd.job_len_c = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_output("rst_busy", 32'(bus_main.job_busy), 0);
    check_output("rst_error", 32'(bus_main.job_error), 0);
    check_output("rst_err_phase", 32'(bus_main.job_err_phase), 0);
    check_output("rst_start_a", 32'(bus_main.dma_start_load_a), 0);
    check_output("rst_base_a", bus_main.dma_base_addr_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal job, with a second job_start mid-job that must be ignored
    snapshot();
    start_job(32'h1000, 32'h2000, 32'h3000, 8'd4, 8'd4, 8'd4);
    check_output("t1_busy_after_start", 32'(bus_main.job_busy), 1);
    check_output("t1_start_a_not_early", 32'(bus_main.dma_start_load_a), 0);
    @(negedge clk);
    check_output("t1_start_a_latency", 32'(bus_main.dma_start_load_a), 1);
    check_output("t1_base_a", bus_main.dma_base_addr_a, 32'h1000);
    start_job(32'h9000, 32'h9100, 32'h9200, 8'd7, 8'd7, 8'd7);
    check_output("t5_base_a_held", bus_main.dma_base_addr_a, 32'h1000);
    check_output("t5_base_c_held", bus_main.dma_base_addr_c, 32'h3000);
    check_output("t5_len_b_held", 32'(bus_main.dma_length_b), 4);
    wait_done("t1");
    check_output("t1_n_a", 32'(n_a - s_a), 1);
    check_output("t1_n_b", 32'(n_b - s_b), 1);
    check_output("t1_n_mac", 32'(n_mac - s_mac), 1);
    check_output("t1_n_c", 32'(n_c - s_c), 1);
    check_output("t1_n_done", 32'(n_done - s_done), 1);
    check_output("t1_busy_falls", 32'(n_busy_fall - s_fall), 1);
    check_output("t1_a_to_b", 32'(t_b - t_a), 12);
    check_output("t1_b_to_mac", 32'(t_mac - t_b), 12);
    check_output("t1_mac_to_c", 32'(t_c - t_mac), 22);
    check_output("t1_c_to_done", 32'(t_done - t_c), 11);
    check_output("t5_base_b_after", bus_main.dma_base_addr_b, 32'h2000);

    // Zero-length B phase is skipped
    snapshot();
    start_job(32'h4000, 32'h5000, 32'h6000, 8'd2, 8'd0, 8'd2);
    wait_done("t2");
    check_output("t2_no_start_b", 32'(n_b - s_b), 0);
    check_output("t2_n_a", 32'(n_a - s_a), 1);
    check_output("t2_n_mac", 32'(n_mac - s_mac), 1);
    check_output("t2_n_c", 32'(n_c - s_c), 1);
    check_output("t2_a_to_mac", 32'(t_mac - t_a), 13);
    check_output("t2_len_b", 32'(bus_main.dma_length_b), 0);

    // dma_busy holds off the first start pulse
    bus_main.dma_busy = 1'b1;
    start_job(32'h1100, 32'h2200, 32'h3300, 8'd4, 8'd4, 8'd4);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | bus_main.dma_start_load_a;
    end
    check_output("t3_no_early_start", 32'(seen), 0);
    bus_main.dma_busy = 1'b0;
    @(negedge clk);
    check_output("t3_start_after_busy", 32'(bus_main.dma_start_load_a), 1);
    wait_done("t3");

    // Asynchronous reset during WAIT_B, then a clean job
    start_job(32'h7000, 32'h7100, 32'h7200, 8'd4, 8'd4, 8'd4);
    for (int i = 0; i < 100 && !bus_main.dma_start_load_b; i++) @(negedge clk);
    check_output("t6_reached_b", 32'(bus_main.dma_start_load_b), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_busy", 32'(bus_main.job_busy), 0);
    check_output("t6_rst_base_b", bus_main.dma_base_addr_b, 0);
    check_output("t6_rst_len_a", 32'(bus_main.dma_length_a), 0);
    check_output("t6_rst_mac_start", 32'(bus_main.mac_start), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snapshot();
    start_job(32'h8000, 32'h8100, 32'h8200, 8'd1, 8'd1, 8'd1);
    wait_done("t6");
    check_output("t6_n_a", 32'(n_a - s_a), 1);
    check_output("t6_n_b", 32'(n_b - s_b), 1);
    check_output("t6_n_c", 32'(n_c - s_c), 1);
    check_output("t6_base_b", bus_main.dma_base_addr_b, 32'h8100);
    check_output("t6_error", 32'(bus_main.job_error), 0);

    // Watchdog (TIMEOUT_W=4): MAC never completes
    bus_wd.job_base_a = 32'h40; bus_wd.job_base_b = 32'h44; bus_wd.job_base_c = 32'h48;
    bus_wd.job_len_a = 8'd0; bus_wd.job_len_b = 8'd0; bus_wd.job_len_c = 8'd2;
    bus_wd.job_start = 1'b1;
    @(negedge clk);
    bus_wd.job_start = 1'b0;
    check_output("t4_busy", 32'(bus_wd.job_busy), 1);
    repeat (3) @(negedge clk);
    check_output("t4_mac_start", 32'(bus_wd.mac_start), 1);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      seen = seen | bus_wd.job_done | bus_wd.dma_start_store_c | bus_wd.mac_start;
    end
    check_output("t4_no_error_early", 32'(bus_wd.job_error), 0);
    @(negedge clk);
    check_output("t4_error", 32'(bus_wd.job_error), 1);
    check_output("t4_err_phase", 32'(bus_wd.job_err_phase), 2);
    check_output("t4_busy_dropped", 32'(bus_wd.job_busy), 0);
    for (int i = 0; i < 6; i++) begin
      seen = seen | bus_wd.job_done | bus_wd.dma_start_store_c | bus_wd.mac_start
                  | bus_wd.dma_start_load_a | bus_wd.dma_start_load_b;
      @(negedge clk);
    end
    check_output("t4_no_pulses", 32'(seen), 0);
    check_output("t4_error_sticky", 32'(bus_wd.job_error), 1);
    check_output("t4_base_held", bus_wd.dma_base_addr_a, 32'h40);
    check_output("t4_len_c_held", 32'(bus_wd.dma_length_c), 2);

    // Next job clears job_error; mac_done in the final watchdog cycle wins
    bus_wd.job_base_a = 32'h50; bus_wd.job_len_c = 8'd0;
    bus_wd.job_start = 1'b1;
    @(negedge clk);
    bus_wd.job_start = 1'b0;
    check_output("t4b_error_cleared", 32'(bus_wd.job_error), 0);
    repeat (3) @(negedge clk);
    check_output("t4b_mac_start", 32'(bus_wd.mac_start), 1);
    repeat (14) @(negedge clk);
    bus_wd.mac_done = 1'b1;
    @(negedge clk);
    bus_wd.mac_done = 1'b0;
    check_output("t4b_done_wins", 32'(bus_wd.job_error), 0);
    check_output("t4b_still_busy", 32'(bus_wd.job_busy), 1);
    @(negedge clk);
    check_output("t4b_job_done", 32'(bus_wd.job_done), 1);
    check_output("t4b_base_a", bus_wd.dma_base_addr_a, 32'h50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
